// File: rtl/train_pkg.sv
// Shared types and constants for the training sequencer: FSM state
// encoding, the drain-length multiplier and the index-width helper.
package train_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        FEED,
        DRAIN,
        COST,
        UPDATE,
        DONE
    } seq_state_t;

    // The array needs 2*SIZE idle cycles to flush a layer's partial sums.
    localparam int DRAIN_MULT = 2;

    // Width of an index into n entries, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_counter.sv
// Up-counter used for the sequencer's row, drain, layer and update
// indices. Counts 0..MAX on enable, wraps, and flags the terminal value.
module seq_counter #(
    parameter int MAX = 1,
    parameter int W   = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);

    // Count register: clear wins over enable, wrap after the terminal value.
    always_ff @(posedge clk) begin
        // NOTE: flops are written with non-blocking assignments only, so every
        // always_ff sees the pre-edge value of every other register.
        if (reset || clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

    assign tc = (count == W'(MAX));

endmodule

// File: rtl/train_sequencer.sv
// Training sequencer for the systolic-array trainer. Walks every layer of
// every epoch through LOAD_W, FEED, DRAIN, then COST and UPDATE, driving
// the weight-storage, input-storage and array strobes from registers.
// Optional build macro TRAIN_SEQ_PERF_EN adds busy/stall cycle counters.
module train_sequencer
    import train_pkg::*;
#(
    parameter int SIZE    = 3,
    parameter int LAYERS  = 2,
    parameter int EPOCH_W = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [EPOCH_W-1:0]          cfg_epochs,
    input  logic                        i_valid,
    output logic                        busy,
    output logic                        done,
    output logic [EPOCH_W-1:0]          epoch_left,
    output logic [idx_w(LAYERS)-1:0]    w_layer_index,
    output logic [idx_w(SIZE)-1:0]      w_row_index,
    output logic                        is_load,
    output logic                        load_w,
    output logic                        i_is_load,
    output logic                        use_z,
    output logic                        backprop_cost,
    output logic                        is_update
`ifdef TRAIN_SEQ_PERF_EN
    ,
    output logic [31:0]                 perf_busy_cycles,
    output logic [31:0]                 perf_stall_cycles
`endif
);

    localparam int LW = idx_w(LAYERS);
    localparam int RW = idx_w(SIZE);
    localparam int DW = idx_w(DRAIN_MULT * SIZE);
    localparam int UW = idx_w(LAYERS * SIZE);

    seq_state_t state, state_nxt;

    logic [RW-1:0] row_cnt, row_nxt;
    logic [DW-1:0] drain_cnt;
    logic [LW-1:0] layer_cnt, layer_nxt;
    logic [UW-1:0] upd_cnt, upd_nxt;
    logic row_clr, row_en, row_tc;
    logic drain_clr, drain_en, drain_tc;
    logic layer_clr, layer_en, layer_tc;
    logic upd_clr, upd_en, upd_tc;

    logic [EPOCH_W-1:0] epoch_nxt;
    logic               feed_beat;

    logic          busy_d, done_d, is_load_d, load_w_d, i_is_load_d;
    logic          use_z_d, backprop_cost_d, is_update_d;
    logic [LW-1:0] w_layer_d;
    logic [RW-1:0] w_row_d;

    // Drain length only matters through its terminal flag.
    logic drain_cnt_unused;
    assign drain_cnt_unused = ^drain_cnt;

    seq_counter #(.MAX(SIZE - 1), .W(RW)) u_row (
        .clk(clk), .reset(reset), .clr(row_clr), .en(row_en),
        .count(row_cnt), .tc(row_tc)
    );
    seq_counter #(.MAX(DRAIN_MULT * SIZE - 1), .W(DW)) u_drain (
        .clk(clk), .reset(reset), .clr(drain_clr), .en(drain_en),
        .count(drain_cnt), .tc(drain_tc)
    );
    seq_counter #(.MAX(LAYERS - 1), .W(LW)) u_layer (
        .clk(clk), .reset(reset), .clr(layer_clr), .en(layer_en),
        .count(layer_cnt), .tc(layer_tc)
    );
    seq_counter #(.MAX(LAYERS * SIZE - 1), .W(UW)) u_upd (
        .clk(clk), .reset(reset), .clr(upd_clr), .en(upd_en),
        .count(upd_cnt), .tc(upd_tc)
    );

    // A layer-0 feed beat happens only when this cycle's pop strobe is up;
    // deeper layers consume z every cycle.
    assign feed_beat = (layer_cnt != '0) || i_is_load;

    // Index values the counters will hold next cycle, used to register outputs.
    assign row_nxt   = row_clr   ? '0 : (row_en   ? row_cnt   + 1'b1 : row_cnt);
    assign layer_nxt = layer_clr ? '0 : (layer_en ? layer_cnt + 1'b1 : layer_cnt);
    assign upd_nxt   = upd_clr   ? '0 : (upd_en   ? upd_cnt   + 1'b1 : upd_cnt);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and counter control.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // through this block infers a latch.
        state_nxt = state;
        epoch_nxt = epoch_left;
        row_clr   = 1'b0; row_en   = 1'b0;
        drain_clr = 1'b0; drain_en = 1'b0;
        layer_clr = 1'b0; layer_en = 1'b0;
        upd_clr   = 1'b0; upd_en   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (cfg_epochs != '0) begin
                        state_nxt = LOAD_W;
                        epoch_nxt = cfg_epochs;
                        row_clr   = 1'b1;
                        layer_clr = 1'b1;
                        drain_clr = 1'b1;
                        upd_clr   = 1'b1;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            LOAD_W: begin
                if (row_tc) begin
                    state_nxt = FEED;
                    row_clr   = 1'b1;
                end else begin
                    row_en = 1'b1;
                end
            end
            FEED: begin
                if (feed_beat) begin
                    if (row_tc) begin
                        state_nxt = DRAIN;
                        row_clr   = 1'b1;
                        drain_clr = 1'b1;
                    end else begin
                        row_en = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (drain_tc) begin
                    drain_clr = 1'b1;
                    row_clr   = 1'b1;
                    if (layer_tc) begin
                        state_nxt = COST;
                    end else begin
                        state_nxt = LOAD_W;
                        layer_en  = 1'b1;
                    end
                end else begin
                    drain_en = 1'b1;
                end
            end
            COST: begin
                if (row_tc) begin
                    state_nxt = UPDATE;
                    row_clr   = 1'b1;
                    upd_clr   = 1'b1;
                end else begin
                    row_en = 1'b1;
                end
            end
            UPDATE: begin
                if (upd_tc) begin
                    upd_clr   = 1'b1;
                    row_clr   = 1'b1;
                    layer_clr = 1'b1;
                    epoch_nxt = epoch_left - 1'b1;
                    state_nxt = (epoch_left == EPOCH_W'(1)) ? DONE : LOAD_W;
                end else begin
                    upd_en = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Decode next cycle's strobes and indices from the next state.
    always_comb begin
        busy_d          = 1'b0;
        done_d          = 1'b0;
        is_load_d       = 1'b0;
        load_w_d        = 1'b0;
        i_is_load_d     = 1'b0;
        use_z_d         = 1'b0;
        backprop_cost_d = 1'b0;
        is_update_d     = 1'b0;
        w_layer_d       = '0;
        w_row_d         = '0;
        case (state_nxt)
            LOAD_W: begin
                busy_d    = 1'b1;
                is_load_d = 1'b1;
                load_w_d  = 1'b1;
                w_layer_d = layer_nxt;
                w_row_d   = row_nxt;
            end
            FEED: begin
                busy_d    = 1'b1;
                w_layer_d = layer_nxt;
                w_row_d   = row_nxt;
                if (layer_nxt == '0) i_is_load_d = i_valid;
                else                 use_z_d     = 1'b1;
            end
            DRAIN: busy_d = 1'b1;
            COST: begin
                busy_d          = 1'b1;
                backprop_cost_d = 1'b1;
                use_z_d         = 1'b1;
                w_layer_d       = LW'(LAYERS - 1);
                w_row_d         = row_nxt;
            end
            UPDATE: begin
                busy_d      = 1'b1;
                is_update_d = 1'b1;
                w_layer_d   = LW'(32'(upd_nxt) / SIZE);
                w_row_d     = RW'(32'(upd_nxt) % SIZE);
            end
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    // Output registers; reset drops every strobe immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy          <= 1'b0;
            done          <= 1'b0;
            epoch_left    <= '0;
            w_layer_index <= '0;
            w_row_index   <= '0;
            is_load       <= 1'b0;
            load_w        <= 1'b0;
            i_is_load     <= 1'b0;
            use_z         <= 1'b0;
            backprop_cost <= 1'b0;
            is_update     <= 1'b0;
        end else begin
            busy          <= busy_d;
            done          <= done_d;
            epoch_left    <= epoch_nxt;
            w_layer_index <= w_layer_d;
            w_row_index   <= w_row_d;
            is_load       <= is_load_d;
            load_w        <= load_w_d;
            i_is_load     <= i_is_load_d;
            use_z         <= use_z_d;
            backprop_cost <= backprop_cost_d;
            is_update     <= is_update_d;
        end
    end

`ifdef TRAIN_SEQ_PERF_EN
    // Saturating busy and input-stall counters, cleared on each accepted start.
    always_ff @(posedge clk) begin
        if (reset || (state == IDLE && start)) begin
            perf_busy_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (busy && perf_busy_cycles != '1)
                perf_busy_cycles <= perf_busy_cycles + 32'd1;
            if (state == FEED && layer_cnt == '0 && !i_valid && perf_stall_cycles != '1)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`else
    // Default build carries no performance counters.
`endif

endmodule

// File: tb/tb_train_sequencer.sv
// Directed bench for train_sequencer: expected per-cycle output vectors are
// queued from the phase schedule, then popped and compared each cycle.
module tb_train_sequencer;
    import train_pkg::*;

    localparam int SIZE    = 3;
    localparam int LAYERS  = 2;
    localparam int EPOCH_W = 8;
    localparam int LW      = idx_w(LAYERS);
    localparam int RW      = idx_w(SIZE);

    logic               clk;
    logic               reset;
    logic               start;
    logic [EPOCH_W-1:0] cfg_epochs;
    logic               i_valid;
    logic               busy, done;
    logic [EPOCH_W-1:0] epoch_left;
    logic [LW-1:0]      w_layer_index;
    logic [RW-1:0]      w_row_index;
    logic               is_load, load_w, i_is_load, use_z, backprop_cost, is_update;
`ifdef TRAIN_SEQ_PERF_EN
    logic [31:0]        perf_busy_cycles, perf_stall_cycles;
`endif

    typedef struct packed {
        logic               busy;
        logic               done;
        logic [EPOCH_W-1:0] ep;
        logic [LW-1:0]      wl;
        logic [RW-1:0]      wr;
        logic               ld;
        logic               lw;
        logic               iil;
        logic               uz;
        logic               bp;
        logic               up;
    } obs_t;

    obs_t obs;
    obs_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   poke_at     = 0;
    int   stall_lo    = 0;
    int   stall_hi    = -1;
    int   rst_at      = 0;

    train_sequencer #(.SIZE(SIZE), .LAYERS(LAYERS), .EPOCH_W(EPOCH_W)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .cfg_epochs(cfg_epochs),
        .i_valid(i_valid),
        .busy(busy),
        .done(done),
        .epoch_left(epoch_left),
        .w_layer_index(w_layer_index),
        .w_row_index(w_row_index),
        .is_load(is_load),
        .load_w(load_w),
        .i_is_load(i_is_load),
        .use_z(use_z),
        .backprop_cost(backprop_cost),
        .is_update(is_update)
`ifdef TRAIN_SEQ_PERF_EN
        ,
        .perf_busy_cycles(perf_busy_cycles),
        .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    assign obs = {busy, done, epoch_left, w_layer_index, w_row_index,
                  is_load, load_w, i_is_load, use_z, backprop_cost, is_update};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t mk(input logic b, input logic d, input logic [EPOCH_W-1:0] ep,
                                input int wl, input int wr, input logic ld, input logic iil,
                                input logic uz, input logic bp, input logic up);
        obs_t o;
        o.busy = b;  o.done = d;  o.ep = ep;
        o.wl   = LW'(wl);  o.wr = RW'(wr);
        o.ld   = ld; o.lw = ld; o.iil = iil; o.uz = uz; o.bp = bp; o.up = up;
        return o;
    endfunction

    task automatic push_idle(input logic [EPOCH_W-1:0] ep, input int n);
        repeat (n) sb.push_back(mk(1'b0, 1'b0, ep, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic push_done();
        sb.push_back(mk(1'b0, 1'b1, '0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    // One epoch of the schedule; optional stall cycles before a layer-0 feed row.
    task automatic push_epoch(input logic [EPOCH_W-1:0] ep, input int stall_row, input int stall_len);
        for (int l = 0; l < LAYERS; l++) begin
            for (int r = 0; r < SIZE; r++)
                sb.push_back(mk(1'b1, 1'b0, ep, l, r, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
            for (int r = 0; r < SIZE; r++) begin
                if (l == 0 && r == stall_row)
                    repeat (stall_len)
                        sb.push_back(mk(1'b1, 1'b0, ep, 0, r, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
                sb.push_back(mk(1'b1, 1'b0, ep, l, r, 1'b0, l == 0, l != 0, 1'b0, 1'b0));
            end
            repeat (2 * SIZE)
                sb.push_back(mk(1'b1, 1'b0, ep, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        for (int r = 0; r < SIZE; r++)
            sb.push_back(mk(1'b1, 1'b0, ep, LAYERS - 1, r, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
        for (int u = 0; u < LAYERS * SIZE; u++)
            sb.push_back(mk(1'b1, 1'b0, ep, u / SIZE, u % SIZE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    endtask

    task automatic launch(input logic [EPOCH_W-1:0] n);
        @(negedge clk);
        cfg_epochs = n;
        start      = 1'b1;
    endtask

    // Compare n cycles against the scoreboard, applying scheduled pokes.
    task automatic run(input int n, input string tag);
        obs_t exp;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL %s cycle %0d: scoreboard empty, observed %h", tag, k, obs);
            end else begin
                exp = sb.pop_front();
                assert (obs === exp) else begin
                    miscompares++;
                    $error("FAIL %s cycle %0d: observed %h expected %h", tag, k, obs, exp);
                end
            end
            start   = (k == poke_at);
            if (k == poke_at) cfg_epochs = 8'd7;
            i_valid = !(k >= stall_lo && k <= stall_hi);
            reset   = (k == rst_at);
        end
        poke_at  = 0;
        stall_lo = 0;
        stall_hi = -1;
        rst_at   = 0;
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        cfg_epochs = '0;
        i_valid    = 1'b1;
        repeat (2) @(posedge clk);

        // Reset state.
        push_idle('0, 2);
        rst_at = 1;
        run(2, "reset");

        // Single epoch, no stalls: 33 busy cycles, done in cycle 34.
        launch(8'd1);
        push_epoch(8'd1, -1, 0);
        push_done();
        push_idle('0, 2);
        run(36, "epoch1");

        // Three epochs with an ignored start/cfg poke mid-run.
        launch(8'd3);
        push_epoch(8'd3, -1, 0);
        push_epoch(8'd2, -1, 0);
        push_epoch(8'd1, -1, 0);
        push_done();
        push_idle('0, 2);
        poke_at = 40;
        run(102, "epoch3");

        // Input stall during the second layer-0 feed row.
        launch(8'd1);
        push_epoch(8'd1, 1, 4);
        push_done();
        push_idle('0, 2);
        stall_lo = 4;
        stall_hi = 7;
        run(40, "stall");
`ifdef TRAIN_SEQ_PERF_EN
        vectors++;
        assert (perf_busy_cycles === 32'd37) else begin
            miscompares++;
            $error("FAIL perf_busy: observed %0d expected 37", perf_busy_cycles);
        end
        vectors++;
        assert (perf_stall_cycles === 32'd4) else begin
            miscompares++;
            $error("FAIL perf_stall: observed %0d expected 4", perf_stall_cycles);
        end
`endif

        // Reset in the middle of UPDATE aborts the run.
        launch(8'd2);
        push_epoch(8'd2, -1, 0);
        repeat (3) void'(sb.pop_back());
        push_idle('0, 3);
        rst_at = 30;
        run(33, "abort");

        // Zero epochs: straight to DONE, no strobes, busy never rises.
        launch(8'd0);
        push_done();
        push_idle('0, 2);
        run(3, "zero");
`ifdef TRAIN_SEQ_PERF_EN
        vectors++;
        assert (perf_busy_cycles === 32'd0) else begin
            miscompares++;
            $error("FAIL perf_zero: observed %0d expected 0", perf_busy_cycles);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
